// File: rtl/dmem_pkg.sv
// Shared encodings and request checking for the sized data memory.
package dmem_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Illegal size, misaligned halfword/word, or word index beyond the array.
  function automatic logic dmem_fault(input logic [1:0] size,
                                      input logic [31:0] addr,
                                      input int unsigned depth);
    logic f;
    f = (size == 2'b11)
      || ((size == SZ_HALF) && addr[0])
      || ((size == SZ_WORD) && (addr[1:0] != 2'b00))
      || ({2'b00, addr[31:2]} >= 32'(depth));
    return f;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        unsigned_ld,
  input  logic [31:0] wd,
  input  logic [31:0] raw,
  output logic [3:0]  wmask_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store path: replicate lane data across the word and enable only the addressed bytes.
  always_comb begin
    wmask_c = 4'b0000;
    wdata_c = wd;
    case (size)
      SZ_BYTE: begin
        wmask_c = 4'b0001 << addr_lo;
        wdata_c = {4{wd[7:0]}};
      end
      SZ_HALF: begin
        wmask_c = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wd[15:0]}};
      end
      SZ_WORD: wmask_c = 4'b1111;
      default: wmask_c = 4'b0000;
    endcase
  end

  // Load path: pick the addressed lane, then sign- or zero-extend it.
  always_comb begin
    ld_byte = raw[7:0];
    ld_half = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (addr_lo)
      2'd0:    ld_byte = raw[7:0];
      2'd1:    ld_byte = raw[15:8];
      2'd2:    ld_byte = raw[23:16];
      default: ld_byte = raw[31:24];
    endcase
    case (size)
      SZ_BYTE: rdata_c = unsigned_ld ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: rdata_c = unsigned_ld ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: rdata_c = raw;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// DEPTH-word data memory with sized little-endian accesses, fault detection
// and a req/ready handshake with LATENCY wait states.
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned LATENCY        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        ready,
  output logic        fault,
  output logic        stall
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem_q [0:DEPTH-1];

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [1:0]       lo_q, lo_d;
  logic [31:0]      wd_q, wd_d;
  logic [31:0]      rd_q, rd_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             mem_we_c;

  logic [3:0]  wmask_c;
  logic [31:0] wdata_c;
  logic [31:0] ld_data_c;

  dmem_lane_align u_align (
    .size        (size_q),
    .addr_lo     (lo_q),
    .unsigned_ld (uns_q),
    .wd          (wd_q),
    .raw         (mem_q[idx_q]),
    .wmask_c     (wmask_c),
    .wdata_c     (wdata_c),
    .rdata_c     (ld_data_c)
  );

  assign RD    = rd_q;
  assign ready = ready_q;
  assign fault = fault_q;
  // Stall while a request is outstanding; the response cycle releases the pipeline.
  assign stall = req & (state_q != ST_RESP);

  // Next-state, input latching, wait-state counting and access control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    idx_d    = idx_q;
    lo_d     = lo_q;
    wd_d     = wd_q;
    rd_d     = rd_q;
    ready_d  = 1'b0;
    fault_d  = 1'b0;
    mem_we_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d   = we;
          size_d = size;
          uns_d  = unsigned_ld;
          idx_d  = A[AW+1:2];
          lo_d   = A[1:0];
          wd_d   = WD;
          if (dmem_fault(size, A, DEPTH)) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            fault_d = 1'b1;
            rd_d    = 32'h0;
          end else begin
            cnt_d   = CNT_W'(LATENCY);
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          if (we_q) mem_we_c = 1'b1;
          else      rd_d     = ld_data_c;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      idx_q   <= '0;
      lo_q    <= 2'b00;
      wd_q    <= 32'h0;
      rd_q    <= 32'h0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  // Memory array: optional clear on reset, byte-masked write otherwise; reset drops a pending write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (CLEAR_ON_RESET != 0) begin
        for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 32'h0;
      end
    end else if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_c[b]) mem_q[idx_q][8*b +: 8] <= wdata_c[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/data_memory_sized.md
# data_memory_sized

Parametrised successor to the single-word MIPS data memory: a DEPTH-word RAM supporting byte, halfword and word loads and stores (little-endian, sign/zero extension), with misalignment and range fault detection. Sits in the MEM stage. A req/ready handshake with a configurable wait-state count lets the pipeline stall on slow memory.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words; word index = A[31:2]
- LATENCY, 0, extra wait cycles per legal access (0..15)
- CLEAR_ON_RESET, 1, 1 = every memory word cleared during reset

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- req  in  1  access request; held high until ready
- we  in  1  1 = store, 0 = load; sampled with req
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- unsigned_ld  in  1  1 = zero-extend byte/halfword loads
- A  in  32  byte address
- WD  in  32  store data; lane data taken from the low bits
- RD  out  32  load result, registered, held until the next completion
- ready  out  1  one-cycle completion pulse
- fault  out  1  valid with ready: misaligned, out-of-range or illegal size
- stall  out  1  combinational: req & ~ready

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: when req=1, latch we, size, unsigned_ld, A and WD, then check the request:
  - Fault if size=11, size=01 with A[0]=1, size=10 with A[1:0]≠0, or A[31:2] ≥ DEPTH.
  - Fault: go to RESP with fault_q=1; no memory access; RD is set to 0.
  - No fault: load cnt=LATENCY and go to BUSY.
- BUSY:
  - cnt≠0: decrement cnt.
  - cnt=0: perform the access at this edge, then go to RESP.
- Store:
  - Write only the addressed lanes: byte lane A[1:0], or halfword lanes {A[1],0}+1..0.
  - Other bytes of the word are unchanged; RD is unchanged.
- Load:
  - Extract the lane; sign-extend from bit 7/15 unless unsigned_ld=1.
  - Word loads pass through unchanged.
  - Register the result into RD.
- RESP: ready=1 and fault=fault_q for exactly one cycle, then go to IDLE unconditionally. req is ignored in RESP.
- req is sampled only in IDLE. A req still high on the cycle after ready starts a new transaction.
- Inputs are latched at acceptance, so changes during BUSY have no effect.

## Timing
- Legal access: req first high in cycle 0 (IDLE) gives ready in cycle LATENCY+2.
- Store data is visible to a load accepted in any later transaction.
- Fault: ready in cycle 1.
- Back-to-back throughput: legal access once per LATENCY+3 cycles.
- Reset (reset=0 at an edge), including mid-transaction:
  - State goes to IDLE, cnt=0, RD=0, ready=0, fault=0.
  - Any pending write is dropped.
  - If CLEAR_ON_RESET=1, all words are set to 0 at that edge.
- stall is combinational from req and the state. It is 0 whenever req=0, and 0 in the RESP cycle.

## Structure
- Package dmem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state encoding, and a fault-check function.
- Sub-module dmem_lane_align: purely combinational. Provides:
  - store path: per-byte write mask plus shifted write data, from size, A[1:0] and WD;
  - load path: lane extraction and sign/zero extension, from size, A[1:0], unsigned_ld and the raw word.
- The top level holds the memory array, the input latches, the FSM and cnt.

## Test plan
- Reset, then load word at A=0x00000000 → RD=0x00000000, ready in cycle 2 (LATENCY=0), fault=0.
- Store word 0x11223344 at A=0x4, then store byte 0xAB at A=0x5. Load word at A=0x4 → RD=0x1122AB44.
- Same memory state, load byte at A=0x5 → RD=0xFFFFFFAB. With unsigned_ld=1 → 0x000000AB. Load halfword at A=0x6 → RD=0x00001122.
- Faults, each with ready in cycle 1, fault=1, RD=0 and memory unchanged:
  - halfword at A=0x3;
  - word at A=0x2;
  - size=11;
  - A=DEPTH*4.
- LATENCY=3:
  - store at A=0x8 → ready in cycle 5, stall high in cycles 0-4;
  - reset asserted in cycle 2 → no ready, and a later load of A=0x8 returns 0.
- Two back-to-back stores with req held high through ready → both complete, second ready LATENCY+3 cycles after the first.
